// File: rtl/serial_addsub_if.sv
// Handshake and data bundle for the digit-serial add/subtract unit.
// The requester drives master; the arithmetic unit takes the slave side.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, mode, cin, a, b,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, mode, cin, a, b,
    output busy, done, result, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit add/subtract, CHUNK bits per clock, LSB first.
// Flags and result are registered together on the final chunk edge.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] res_q;
  logic             op_add;
  logic             carry;
  logic             cy_nx;
  logic             ovf_nx;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK:0]   part;
  logic             last;
  logic             accept;
  int               off;

  always_comb begin
    off    = int'(idx) * CHUNK;
    ca     = CHUNK'(op_a >> off);
    cb     = CHUNK'(op_b >> off);
    // Borrow shows up as the wrapped top bit of the widened difference.
    if (op_add) begin
      part = {1'b0, ca} + {1'b0, cb}
           + {{CHUNK{1'b0}}, carry};
    end else begin
      part = {1'b0, ca} - {1'b0, cb}
           - {{CHUNK{1'b0}}, carry};
    end
    cy_nx  = part[CHUNK];
    acc_nx = acc
           | (WIDTH'(part[CHUNK-1:0]) << off);
    ovf_nx = (op_add
             ? (op_a[WIDTH-1] == op_b[WIDTH-1])
             : (op_a[WIDTH-1] != op_b[WIDTH-1]))
           && (acc_nx[WIDTH-1] != op_a[WIDTH-1]);
    last   = (idx == IW'(NCHUNK - 1));
    accept = (state == IDLE) && bus.start;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_add <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      res_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      op_a   <= bus.a;
      op_b   <= bus.b;
      op_add <= bus.mode;
      carry  <= bus.cin;
      idx    <= '0;
      acc    <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nx;
      carry <= cy_nx;
      idx   <= idx + IW'(1);
      if (last) begin
        res_q  <= acc_nx;
        cout_q <= cy_nx;
        ovf_q  <= ovf_nx;
        zero_q <= (acc_nx == '0);
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed and exhaustive checks of serial_addsub at 8/4, 4/1 and 4/4.
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  serial_addsub_if #(.WIDTH(8)) b8 ();
  serial_addsub_if #(.WIDTH(4)) b41 ();
  serial_addsub_if #(.WIDTH(4)) b44 ();

  serial_addsub #(.WIDTH(8), .CHUNK(4)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  serial_addsub #(.WIDTH(4), .CHUNK(1)) u41 (
    .clk(clk), .rst_n(rst_n), .bus(b41)
  );
  serial_addsub #(.WIDTH(4), .CHUNK(4)) u44 (
    .clk(clk), .rst_n(rst_n), .bus(b44)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs8();
    return {19'd0, b8.busy, b8.done, b8.cout,
            b8.ovf, b8.zero, b8.result};
  endfunction

  // Called on a falling edge; returns on the falling edge where busy drops.
  task automatic op8(input string tag,
                     input logic m, input logic c,
                     input logic [7:0] x, input logic [7:0] y,
                     input int spur,
                     input logic [7:0] er,
                     input logic [2:0] ef);
    logic [7:0] prev;
    logic [7:0] r;
    logic [2:0] f;
    int lat;
    int bcnt;
    int pulses;
    bit seen;
    prev = b8.result;
    r = '0; f = '0;
    lat = 0; bcnt = 0; pulses = 0; seen = 0;
    b8.start = 1'b1; b8.mode = m; b8.cin = c;
    b8.a = x; b8.b = y;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      b8.start = 1'b0;
      b8.mode = ~m; b8.cin = ~c;
      b8.a = ~x; b8.b = ~y;
      if (b8.busy) bcnt++;
      if (b8.done) begin
        pulses++;
        if (!seen) begin
          lat = k;
          r = b8.result;
          f = {b8.cout, b8.ovf, b8.zero};
        end
        seen = 1;
        if (spur > 0) begin
          b8.start = 1'b1;
          b8.a = 8'hFF; b8.b = 8'hFF; b8.mode = 1'b1;
        end
      end else if (b8.busy) begin
        check({tag, " hold"}, 32'(b8.result), 32'(prev));
        if (spur > 0 && k >= spur) begin
          b8.start = 1'b1;
          b8.a = 8'hFF; b8.b = 8'hFF; b8.mode = 1'b1;
        end
      end
      if (seen && !b8.busy) break;
    end
    b8.start = 1'b0;
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " busy cycles"}, 32'(bcnt), 32'd3);
    check({tag, " done pulses"}, 32'(pulses), 32'd1);
    check({tag, " result"}, 32'(r), 32'(er));
    check({tag, " c/v/z"}, 32'(f), 32'(ef));
    check({tag, " idle result"}, 32'(b8.result), 32'(er));
  endtask

  // Runs one 4-bit operation on both narrow instances against a model.
  task automatic op4(input logic m, input logic c,
                     input logic [3:0] x, input logic [3:0] y);
    logic [4:0] full;
    logic [3:0] er;
    logic ec, ev, ez;
    logic [10:0] g1, g4;
    bit s1, s4;
    if (m) full = {1'b0, x} + {1'b0, y} + {4'd0, c};
    else   full = {1'b0, x} - {1'b0, y} - {4'd0, c};
    er = full[3:0];
    ec = full[4];
    ev = (m ? (x[3] == y[3]) : (x[3] != y[3]))
       && (er[3] != x[3]);
    ez = (er == 4'd0);
    g1 = '0; g4 = '0; s1 = 0; s4 = 0;
    b41.start = 1'b1; b41.mode = m; b41.cin = c;
    b41.a = x; b41.b = y;
    b44.start = 1'b1; b44.mode = m; b44.cin = c;
    b44.a = x; b44.b = y;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      b41.start = 1'b0; b41.a = ~x;
      b44.start = 1'b0; b44.b = ~y;
      if (b41.done && !s1) begin
        s1 = 1;
        g1 = {4'(k), b41.cout, b41.ovf, b41.zero, b41.result};
      end
      if (b44.done && !s4) begin
        s4 = 1;
        g4 = {4'(k), b44.cout, b44.ovf, b44.zero, b44.result};
      end
      if (s1 && s4 && !b41.busy && !b44.busy) break;
    end
    check("sweep chunk1", 32'(g1),
          32'({4'd5, ec, ev, ez, er}));
    check("sweep chunk4", 32'(g4),
          32'({4'd2, ec, ev, ez, er}));
  endtask

  initial begin
    int pulses;
    b8.start = 0; b8.mode = 0; b8.cin = 0; b8.a = 0; b8.b = 0;
    b41.start = 0; b41.mode = 0; b41.cin = 0; b41.a = 0; b41.b = 0;
    b44.start = 0; b44.mode = 0; b44.cin = 0; b44.a = 0; b44.b = 0;
    #2 rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      b8.start = 1'b1;
      b8.a = 8'($urandom);
      b8.b = 8'($urandom);
    end
    check("reset held", outs8(), 32'd0);
    @(negedge clk);
    b8.start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("after release", outs8(), 32'd0);

    op8("sub 35-12", 0, 0, 8'h35, 8'h12, 0, 8'h23, 3'b000);
    op8("sub 00-01", 0, 0, 8'h00, 8'h01, 0, 8'hFF, 3'b100);
    op8("sub 80-01", 0, 0, 8'h80, 8'h01, 0, 8'h7F, 3'b010);
    op8("bin 05-05", 0, 1, 8'h05, 8'h05, 0, 8'hFF, 3'b100);
    op8("bin 05-04", 0, 1, 8'h05, 8'h04, 0, 8'h00, 3'b001);
    op8("add 7F+01", 1, 0, 8'h7F, 8'h01, 0, 8'h80, 3'b010);
    op8("add FF+00+1", 1, 1, 8'hFF, 8'h00, 0, 8'h00, 3'b101);
    op8("b2b first", 1, 0, 8'h12, 8'h34, 0, 8'h46, 3'b000);
    op8("b2b second", 0, 0, 8'h46, 8'h46, 0, 8'h00, 3'b001);
    op8("busy start", 0, 0, 8'h40, 8'h10, 1, 8'h30, 3'b000);

    b8.start = 1'b1; b8.mode = 1'b1; b8.cin = 1'b0;
    b8.a = 8'h12; b8.b = 8'h34;
    @(negedge clk);
    b8.start = 1'b0;
    check("abort busy", 32'(b8.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort outs", outs8(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (b8.done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    check("abort idle", outs8(), 32'd0);
    op8("recover", 1, 0, 8'h01, 8'h01, 0, 8'h02, 3'b000);

    for (int m = 0; m < 2; m++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            op4(1'(m), 1'(c), 4'(x), 4'(y));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
